// File: rtl/seq_bit_serializer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seq_bit_serializer_pkg: shared state encodings for the serial 1010 path     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package seq_bit_serializer_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  // Downstream overlapping Mealy 1010 detector: S<n> = length of matched prefix
  typedef enum logic [1:0] {
    DET_S0 = 2'd0,
    DET_S1 = 2'd1,
    DET_S2 = 2'd2,
    DET_S3 = 2'd3
  } det_state_e;

  function automatic int idx_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_bit_serializer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seq_bit_serializer: valid/ready word in, one bit per clk out, 1-word hold   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module seq_bit_serializer
  import seq_bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] c_last_idx = IW'(WIDTH - 1);

  logic             r_state;
  logic             w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] w_shift_adv;
  logic             w_accept;
  logic             w_shifting;
  logic             w_last;
  logic             w_drain;
  logic             w_load_in;
  logic             w_to_hold;

  assign in_ready   = ~rst & ~r_hold_full;
  assign w_accept   = in_valid & in_ready;
  assign w_shifting = (r_state == ST_SHIFT);
  assign w_last     = w_shifting & (r_idx == c_last_idx);
  assign w_drain    = w_last & r_hold_full;
  // New word goes straight to the shifter when idle or on an empty-hold last bit
  assign w_load_in  = w_accept & (~w_shifting | (w_last & ~r_hold_full));
  assign w_to_hold  = w_accept & w_shifting & ~(w_last & ~r_hold_full);

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_adv = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_shift_adv = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = ST_SHIFT;
      end
      default: begin
        if (w_last & ~r_hold_full & ~w_accept) w_state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    bit_valid   = w_shifting;
    frame_start = w_shifting & (r_idx == '0);
    busy        = w_shifting | r_hold_full;
    bit_out     = IDLE_BIT;
    if (w_shifting) bit_out = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_idx       <= '0;
    end else begin
      if (w_drain) begin
        r_shift <= r_hold;
        r_idx   <= '0;
      end else if (w_load_in) begin
        r_shift <= in_data;
        r_idx   <= '0;
      end else if (w_last) begin
        r_idx   <= '0;
      end else if (w_shifting) begin
        r_shift <= w_shift_adv;
        r_idx   <= r_idx + IW'(1);
      end
      if (w_to_hold) r_hold <= in_data;
      r_hold_full <= (r_hold_full & ~w_drain) | w_to_hold;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_bit_serializer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_seq_bit_serializer: scoreboard bench with a reference 1010 detector      |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_seq_bit_serializer;
  import seq_bit_serializer_pkg::*;

  typedef struct packed {
    logic b;
    logic fs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, bit_out, bit_valid, frame_start, busy;
  logic [7:0] l_in_data;
  logic       l_in_valid;
  logic       l_in_ready, l_bit_out, l_bit_valid, l_frame_start, l_busy;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  det_state_e det_st;
  int         det_pulses;

  always #5 clk = ~clk;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .frame_start(frame_start), .busy(busy)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(l_in_data), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .bit_out(l_bit_out), .bit_valid(l_bit_valid), .frame_start(l_frame_start), .busy(l_busy)
  );

  // Reference overlapping Mealy 1010 detector fed by the serial stream
  always @(posedge clk) begin
    if (rst) begin
      det_st     <= DET_S0;
      det_pulses <= 0;
    end else begin
      if (det_st == DET_S3 && bit_out == 1'b0) det_pulses <= det_pulses + 1;
      case (det_st)
        DET_S0:  det_st <= bit_out ? DET_S1 : DET_S0;
        DET_S1:  det_st <= bit_out ? DET_S1 : DET_S2;
        DET_S2:  det_st <= bit_out ? DET_S3 : DET_S0;
        default: det_st <= bit_out ? DET_S1 : DET_S2;
      endcase
    end
  end

  task automatic push_word(input logic [7:0] w, input bit msb);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{b: (msb ? w[7-i] : w[i]), fs: (i == 0)});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; l_in_valid = 1'b0; l_in_data = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    n_cmp++;
    if ({bit_valid, frame_start, busy, bit_out} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs: valid/fs/busy/bit=%b want 0000", {bit_valid, frame_start, busy, bit_out});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_single_word();
    exp_t e;
    int   nbits = 0;
    in_data = 8'hA5; in_valid = 1'b1;
    if (in_ready) push_word(8'hA5, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (bit_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL single_bit: got %b, none expected", bit_out); end
        else begin
          e = exp_q.pop_front();
          if ({bit_out, frame_start} !== {e.b, e.fs}) begin
            n_fail++; $display("FAIL single_bit[%0d]: bit/fs=%b%b want %b%b", nbits, bit_out, frame_start, e.b, e.fs);
          end
        end
        nbits++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (nbits != 8 || exp_q.size() != 0) begin n_fail++; $display("FAIL single_count: got %0d bits want 8", nbits); end
    n_cmp++;
    if ({bit_valid, bit_out, busy} !== 3'b000) begin
      n_fail++; $display("FAIL single_idle: valid/bit/busy=%b want 000", {bit_valid, bit_out, busy});
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   nbits = 0, first = -1, last = -1;
    for (int c = 0; c < 22; c++) begin
      if (bit_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_bit: got %b, none expected", bit_out); end
        else begin
          e = exp_q.pop_front();
          if ({bit_out, frame_start} !== {e.b, e.fs}) begin
            n_fail++; $display("FAIL b2b_bit[%0d]: bit/fs=%b%b want %b%b", nbits, bit_out, frame_start, e.b, e.fs);
          end
        end
        n_cmp++;
        if (in_ready !== !(nbits >= 1 && nbits <= 7)) begin
          n_fail++; $display("FAIL b2b_ready[%0d]: got %b want %b", nbits, in_ready, !(nbits >= 1 && nbits <= 7));
        end
        if (first < 0) first = c;
        last = c;
        nbits++;
      end
      in_valid = (c < 2);
      in_data  = (c == 0) ? 8'hAA : 8'h0F;
      if (in_valid && in_ready) push_word(in_data, 1'b1);
      @(negedge clk);
    end
    n_cmp++;
    if (nbits != 16 || (last - first) != 15 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_gapless: got %0d bits over %0d cycles want 16 over 16", nbits, last - first + 1);
    end
    exp_q.delete();
  endtask

  task automatic test_held_valid();
    exp_t       e;
    logic [7:0] words [3] = '{8'h11, 8'h22, 8'h33};
    int         wi = 0, nbits = 0, first = -1, last = -1, nlow = 0;
    for (int c = 0; c < 34; c++) begin
      if (bit_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL held_bit: got %b, none expected", bit_out); end
        else begin
          e = exp_q.pop_front();
          if ({bit_out, frame_start} !== {e.b, e.fs}) begin
            n_fail++; $display("FAIL held_bit[%0d]: bit/fs=%b%b want %b%b", nbits, bit_out, frame_start, e.b, e.fs);
          end
        end
        if (first < 0) first = c;
        last = c;
        nbits++;
      end
      if (!in_ready) nlow++;
      in_valid = (wi < 3);
      in_data  = words[(wi < 3) ? wi : 2];
      if (in_valid && in_ready) begin push_word(in_data, 1'b1); wi++; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_cmp++;
    if (nbits != 24 || (last - first) != 23 || wi != 3 || exp_q.size() != 0 || nlow == 0) begin
      n_fail++; $display("FAIL held_order: got %0d bits/%0d words/%0d ready-low want 24/3/>0", nbits, wi, nlow);
    end
    exp_q.delete();
  endtask

  task automatic test_bypass();
    exp_t e;
    int   nbits = 0, first = -1, last = -1;
    for (int c = 0; c < 22; c++) begin
      if (bit_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bypass_bit: got %b, none expected", bit_out); end
        else begin
          e = exp_q.pop_front();
          if ({bit_out, frame_start} !== {e.b, e.fs}) begin
            n_fail++; $display("FAIL bypass_bit[%0d]: bit/fs=%b%b want %b%b", nbits, bit_out, frame_start, e.b, e.fs);
          end
        end
        if (first < 0) first = c;
        last = c;
        nbits++;
      end
      // Second word arrives while the last bit of the first is on the wire
      in_valid = (c == 0) || (c == 8);
      in_data  = (c == 0) ? 8'h3C : 8'hC3;
      if (in_valid && in_ready) push_word(in_data, 1'b1);
      @(negedge clk);
    end
    n_cmp++;
    if (nbits != 16 || (last - first) != 15 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL bypass_gapless: got %0d bits over %0d cycles want 16 over 16", nbits, last - first + 1);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_midword();
    exp_t e;
    int   nbits = 0;
    for (int c = 0; c < 4; c++) begin
      if (bit_valid === 1'b1) begin
        n_cmp++;
        e = exp_q.pop_front();
        if ({bit_out, frame_start} !== {e.b, e.fs}) begin
          n_fail++; $display("FAIL rstmid_bit[%0d]: bit/fs=%b%b want %b%b", c, bit_out, frame_start, e.b, e.fs);
        end
      end
      in_valid = (c < 2);
      in_data  = (c == 0) ? 8'hF0 : 8'h5A;
      if (c < 3 && in_valid && in_ready) push_word(in_data, 1'b1);
      if (c < 3) @(negedge clk);
    end
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_hold: busy=%b want 1", busy); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready: got %b want 0", in_ready); end
    @(negedge clk);
    n_cmp++;
    if ({bit_valid, busy, frame_start, bit_out} !== 4'b0000) begin
      n_fail++; $display("FAIL rstmid_cleared: valid/busy/fs/bit=%b want 0000", {bit_valid, busy, frame_start, bit_out});
    end
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    in_data = 8'h81; in_valid = 1'b1;
    if (in_ready) push_word(8'h81, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (bit_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL rstmid_new: got %b, none expected", bit_out); end
        else begin
          e = exp_q.pop_front();
          if ({bit_out, frame_start} !== {e.b, e.fs}) begin
            n_fail++; $display("FAIL rstmid_new[%0d]: bit/fs=%b%b want %b%b", nbits, bit_out, frame_start, e.b, e.fs);
          end
        end
        nbits++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (nbits != 8 || exp_q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_count: got %0d bits busy=%b want 8 bits busy=0", nbits, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_lsb_first();
    exp_t e;
    int   nbits = 0;
    l_in_data = 8'h01; l_in_valid = 1'b1;
    if (l_in_ready) push_word(8'h01, 1'b0);
    @(negedge clk);
    l_in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (l_bit_valid === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL lsb_bit: got %b, none expected", l_bit_out); end
        else begin
          e = exp_q.pop_front();
          if ({l_bit_out, l_frame_start} !== {e.b, e.fs}) begin
            n_fail++; $display("FAIL lsb_bit[%0d]: bit/fs=%b%b want %b%b", nbits, l_bit_out, l_frame_start, e.b, e.fs);
          end
        end
        nbits++;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (nbits != 8 || exp_q.size() != 0) begin n_fail++; $display("FAIL lsb_count: got %0d bits want 8", nbits); end
    exp_q.delete();
  endtask

  task automatic test_detector();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (det_pulses != 0) begin n_fail++; $display("FAIL det_idle: got %0d pulses want 0", det_pulses); end
    in_data = 8'hAA; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (det_pulses != 3) begin n_fail++; $display("FAIL det_pulses: got %0d want 3", det_pulses); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_held_valid();
    test_bypass();
    test_reset_midword();
    test_lsb_first();
    test_detector();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests incomplete");
    $fatal(1);
  end

endmodule
`default_nettype wire
